// File: rtl/stopwatch_core_bcd.sv
// stopwatch_core_bcd: N-digit BCD up/down stopwatch with preset load, run/pause/done FSM
// and a multiplexed 7-segment scanner driven by external tick strobes.
module stopwatch_core_bcd #(
  parameter int DIGITS      = 4,
  parameter int LOAD_DIGITS = 2,
  parameter int DP_POS      = 2
) (
  input  logic                     c_clk,
  input  logic                     R,
  input  logic                     clr,
  input  logic                     P,
  input  logic                     cnt_tick,
  input  logic                     scan_tick,
  input  logic [1:0]               sel,
  input  logic [4*LOAD_DIGITS-1:0] load,
  output logic [4*DIGITS-1:0]      count,
  output logic [1:0]               state,
  output logic                     done,
  output logic [DIGITS-1:0]        an,
  output logic [6:0]               sseg,
  output logic                     dp
);
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] r_count;
  logic [1:0]          r_state;
  logic                r_down;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] w_preset;
  logic [4*DIGITS-1:0] w_next;
  logic [DIGITS-1:0]   w_cy;
  logic [DIGITS-1:0]   w_dt;
  logic                w_at_term;
  logic [3:0]          w_digit;

  assign w_cy[0] = 1'b1;

  // Per-digit preset, BCD ripple step and terminal match; w_cy is carry (up) or borrow (down).
  genvar i;
  for (i = 0; i < DIGITS; i++) begin : g_dig
    logic [3:0] w_ld;
    logic [3:0] w_nib;
    if (i >= DIGITS - LOAD_DIGITS) begin : g_ld
      assign w_ld = load[4*(i-DIGITS+LOAD_DIGITS) +: 4] > 4'd9 ? 4'd9 : load[4*(i-DIGITS+LOAD_DIGITS) +: 4];
    end else begin : g_nl
      assign w_ld = 4'd0;
    end
    assign w_nib = r_count[4*i +: 4];
    assign w_preset[4*i +: 4] = sel == 2'd0 ? 4'd0 : sel == 2'd2 ? 4'd9 : w_ld;
    assign w_dt[i] = w_nib == (r_down ? 4'd0 : 4'd9);
    assign w_next[4*i +: 4] = !w_cy[i] ? w_nib :
                              r_down ? (w_nib == 4'd0 ? 4'd9 : w_nib - 4'd1) :
                                       (w_nib == 4'd9 ? 4'd0 : w_nib + 4'd1);
    if (i < DIGITS - 1) begin : g_cy
      assign w_cy[i+1] = w_cy[i] & w_dt[i];
    end
  end

  assign w_at_term = &w_dt;

  always_ff @(posedge c_clk or posedge R) begin
    if (R) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_down  <= 1'b0;
    end else if (clr) begin
      r_state <= S_IDLE;
      r_count <= w_preset;
    end else if (r_state == S_IDLE) begin
      r_count <= w_preset;
      if (P) begin
        r_down  <= sel[1];
        r_state <= S_RUN;
      end
    end else if (r_state == S_RUN) begin
      if (w_at_term) begin
        r_state <= S_DONE;
      end else begin
        if (cnt_tick) r_count <= w_next;
        if (P) r_state <= S_PAUSE;
      end
    end else if (r_state == S_PAUSE) begin
      if (P) r_state <= S_RUN;
    end
  end

  always_ff @(posedge c_clk or posedge R) begin
    if (R) r_idx <= '0;
    else if (scan_tick) r_idx <= r_idx == IW'(DIGITS - 1) ? '0 : r_idx + 1'b1;
  end

  assign w_digit = 4'(r_count >> {r_idx, 2'b00});
  assign count   = r_count;
  assign state   = r_state;
  assign done    = r_state == S_DONE;
  assign an      = DIGITS'(1) << r_idx;
  assign dp      = !(r_idx == IW'(DP_POS));

  always_comb begin
    case (w_digit)
      4'h0: sseg = 7'b0000001;
      4'h1: sseg = 7'b1001111;
      4'h2: sseg = 7'b0010010;
      4'h3: sseg = 7'b0000110;
      4'h4: sseg = 7'b1001100;
      4'h5: sseg = 7'b0100100;
      4'h6: sseg = 7'b0100000;
      4'h7: sseg = 7'b0001111;
      4'h8: sseg = 7'b0000000;
      4'h9: sseg = 7'b0000100;
      4'hA: sseg = 7'b0001000;
      4'hB: sseg = 7'b1100000;
      4'hC: sseg = 7'b0110001;
      4'hD: sseg = 7'b1000010;
      4'hE: sseg = 7'b0110000;
      default: sseg = 7'b0111000;
    endcase
  end
endmodule

// File: tb/tb_stopwatch_core_bcd.sv
// tb_stopwatch_core_bcd: directed plus random checks of 4- and 6-digit stopwatches
// against an integer-valued reference model.
module tb_stopwatch_core_bcd;
  logic c_clk = 1'b0;
  logic R, clr, P, cnt_tick, scan_tick;
  logic [1:0] sel;
  logic [7:0] load;
  logic [15:0] count4;
  logic [23:0] count6;
  logic [1:0] state4, state6;
  logic done4, done6, dp4, dp6;
  logic [3:0] an4;
  logic [5:0] an6;
  logic [6:0] sseg4, sseg6;
  int n_cmp = 0;
  int n_bad = 0;
  int m_st[2], m_val[2], m_idx[2];
  bit m_down[2];
  int nd[2] = '{4, 6};
  logic [6:0] segtab[10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  stopwatch_core_bcd #(.DIGITS(4), .LOAD_DIGITS(2), .DP_POS(2)) dut4 (
    .c_clk(c_clk), .R(R), .clr(clr), .P(P), .cnt_tick(cnt_tick), .scan_tick(scan_tick),
    .sel(sel), .load(load), .count(count4), .state(state4), .done(done4), .an(an4),
    .sseg(sseg4), .dp(dp4));

  stopwatch_core_bcd #(.DIGITS(6), .LOAD_DIGITS(2), .DP_POS(2)) dut6 (
    .c_clk(c_clk), .R(R), .clr(clr), .P(P), .cnt_tick(cnt_tick), .scan_tick(scan_tick),
    .sel(sel), .load(load), .count(count6), .state(state6), .done(done6), .an(an6),
    .sseg(sseg6), .dp(dp6));

  always #5 c_clk = ~c_clk;

  function automatic int pw10(input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r *= 10;
    return r;
  endfunction

  function automatic int preset(input int d, input logic [1:0] s, input logic [7:0] l);
    int h = l[7:4] > 9 ? 9 : int'(l[7:4]);
    int lo = l[3:0] > 9 ? 9 : int'(l[3:0]);
    if (s == 2'd0) return 0;
    if (s == 2'd2) return pw10(d) - 1;
    return (h * 10 + lo) * pw10(d - 2);
  endfunction

  function automatic logic [31:0] bcd(input int v);
    logic [31:0] r = '0;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic [31:0] cnt, input logic [1:0] st, input logic dn,
                           input logic [7:0] a, input logic [6:0] sg, input logic dpv);
    int dig = (m_val[d] / pw10(m_idx[d])) % 10;
    check($sformatf("count%0d", nd[d]), cnt, bcd(m_val[d]));
    check($sformatf("state%0d", nd[d]), 32'(st), 32'(m_st[d]));
    check($sformatf("done%0d", nd[d]), 32'(dn), 32'(m_st[d] == 3));
    check($sformatf("an%0d", nd[d]), 32'(a), 32'(1) << m_idx[d]);
    check($sformatf("sseg%0d", nd[d]), 32'(sg), 32'(segtab[dig]));
    check($sformatf("dp%0d", nd[d]), 32'(dpv), 32'(m_idx[d] != 2));
  endtask

  task automatic check_all();
    check_dut(0, 32'(count4), state4, done4, 8'(an4), sseg4, dp4);
    check_dut(1, 32'(count6), state6, done6, 8'(an6), sseg6, dp6);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0; m_val[d] = 0; m_idx[d] = 0; m_down[d] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int term = m_down[d] ? 0 : pw10(nd[d]) - 1;
      if (clr) begin
        m_st[d] = 0;
        m_val[d] = preset(nd[d], sel, load);
      end else if (m_st[d] == 0) begin
        m_val[d] = preset(nd[d], sel, load);
        if (P) begin m_st[d] = 1; m_down[d] = sel[1]; end
      end else if (m_st[d] == 1) begin
        if (m_val[d] == term) m_st[d] = 3;
        else begin
          if (cnt_tick) m_val[d] += m_down[d] ? -1 : 1;
          if (P) m_st[d] = 2;
        end
      end else if (m_st[d] == 2 && P) m_st[d] = 1;
      if (scan_tick) m_idx[d] = (m_idx[d] + 1) % nd[d];
    end
  endtask

  task automatic step(input logic c, input logic p, input logic t, input logic s);
    clr = c; P = p; cnt_tick = t; scan_tick = s;
    @(posedge c_clk);
    model_edge();
    #1;
    clr = 0; P = 0; cnt_tick = 0; scan_tick = 0;
    check_all();
  endtask

  initial begin
    logic [3:0] an_seq[5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    R = 1; clr = 0; P = 0; cnt_tick = 0; scan_tick = 0; sel = 0; load = 0;
    model_reset();
    #2;
    check_all();
    check("rst_an4", 32'(an4), 32'h1);
    #1 R = 0;
    // mode 0 count and pause
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int k = 0; k < 12; k++) step(0, 0, 1, 0);
    check("t1_count", 32'(count4), 32'h0012);
    step(0, 1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0);
    check("t1_pause", 32'(count4), 32'h0012);
    check("t1_state", 32'(state4), 32'h2);
    // mode 1 preset 99 up to terminal
    sel = 1; load = 8'h99;
    step(1, 0, 0, 0);
    check("t2_preset", 32'(count4), 32'h9900);
    step(0, 1, 0, 0);
    for (int k = 0; k < 99; k++) step(0, 0, 1, 0);
    check("t2_term", 32'(count4), 32'h9999);
    check("t2_run", 32'(state4), 32'h1);
    step(0, 0, 0, 0);
    check("t2_done", 32'(done4), 32'h1);
    for (int k = 0; k < 3; k++) step(0, 1, 1, 0);
    check("t2_hold", 32'(count4), 32'h9999);
    step(1, 0, 0, 0);
    check("t2_clr", 32'(count4), 32'h9900);
    // down modes
    sel = 3; load = 8'h10;
    step(1, 0, 0, 0);
    check("t3_preset", 32'(count4), 32'h1000);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    check("t3_borrow", 32'(count4), 32'h0999);
    sel = 2;
    step(1, 0, 0, 0);
    check("t3_all9", 32'(count4), 32'h9999);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    check("t3_down", 32'(count4), 32'h9998);
    // preset equal to terminal, clamping
    sel = 3; load = 8'h00;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    check("t4_run1", 32'(state4), 32'h1);
    step(0, 0, 0, 0);
    check("t4_done", 32'(state4), 32'h3);
    check("t4_zero", 32'(count4), 32'h0000);
    sel = 1; load = 8'hF3;
    step(1, 0, 0, 0);
    check("t4_clamp", 32'(count4), 32'h9300);
    // scanner
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 1);
      check("t5_an", 32'(an4), 32'(an_seq[k]));
    end
    // six-digit carry across many digits
    sel = 0; load = 8'h00;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int k = 0; k < 9999; k++) step(0, 0, 1, k % 7 == 0);
    check("t6_pre", 32'(count6), 32'h009999);
    step(0, 0, 1, 0);
    check("t6_carry", 32'(count6), 32'h010000);
    #2 R = 1;
    model_reset();
    #1;
    check_all();
    check("t6_async", 32'(count6), 32'h0);
    #1 R = 0;
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check("t6_run", 32'(state6), 32'h1);
    step(1, 1, 0, 0);
    check("t6_clrP", 32'(state6), 32'h0);
    // random
    for (int k = 0; k < 3000; k++) begin
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) load = 8'($urandom);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
